// File: rtl/l2_wb_pkg.sv
// Shared types and constants for the L2 writeback buffer.
// Line/beat geometry, the stored entry layout and the drain FSM state encoding.
package l2_wb_pkg;

  localparam int unsigned LineW    = 256;
  localparam int unsigned BeatW    = 64;
  localparam int unsigned Beats    = LineW / BeatW;
  localparam int unsigned BeatCntW = $clog2(Beats);
  localparam int unsigned TagW     = 27;

  typedef struct packed {
    logic [TagW-1:0]  tag;
    logic [LineW-1:0] line;
  } wb_entry_t;

  typedef enum logic [0:0] {
    IDLE,
    BURST
  } wb_state_t;

endpackage

// File: rtl/l2_wb_drain_fsm.sv
// Drain sequencer: walks the head line out as a 4-beat memory burst and pops it on the last
// accepted beat. Always spends one IDLE cycle between bursts.
module l2_wb_drain_fsm
  import l2_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                empty,
  input  logic                mem_resp,
  output logic                mem_write,
  output logic                pop,
  output logic [BeatCntW-1:0] beat_sel
);

  wb_state_t           state_q, state_d;
  logic [BeatCntW-1:0] cnt_q, cnt_d;
  logic                last_beat;

  assign last_beat = mem_resp && (cnt_q == BeatCntW'(Beats - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = BURST;
          cnt_d   = '0;
        end
      end
      BURST: begin
        // The counter wraps back to zero on the last beat.
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_write = (state_q == BURST);
    pop       = mem_write && last_beat;
    beat_sel  = cnt_q;
  end

endmodule

// File: rtl/l2_writeback_buffer.sv
// L2 writeback buffer: FIFO of evicted dirty lines drained as memory bursts, with a miss lookup.
// Define L2_WB_FORWARD_EN to return the youngest matching line on lkp_line.
module l2_writeback_buffer
  import l2_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned s_line = LineW,
  parameter int unsigned s_beat = BeatW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_addr,
  input  logic [s_line-1:0] wb_line,
  input  logic [31:0]       lkp_addr,
  output logic              lkp_hit,
  output logic [s_line-1:0] lkp_line,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_beat-1:0] mem_wdata,
  input  logic              mem_resp,
  output logic              empty
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  wb_entry_t           entries_q [DEPTH];
  wb_entry_t           entries_d [DEPTH];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d, count;
  logic                full, push, pop;
  logic [BeatCntW-1:0] beat_sel;
  logic [IdxW-1:0]     lkp_idx;
  wb_entry_t           head_entry;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{wb_addr[4:0], lkp_addr[4:0]};

  assign full       = (head_q[IdxW] != tail_q[IdxW]) && (head_q[IdxW-1:0] == tail_q[IdxW-1:0]);
  assign empty      = (head_q == tail_q);
  assign wb_ready   = !full;
  assign push       = wb_valid && !full;
  assign count      = tail_q - head_q;
  assign head_entry = entries_q[head_q[IdxW-1:0]];

  always_comb begin
    head_d = head_q + PtrW'(pop);
    tail_d = tail_q + PtrW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    entries_d = entries_q;
    if (push) entries_d[tail_q[IdxW-1:0]] = '{tag: wb_addr[31:5], line: wb_line};
  end

  // Payload storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  l2_wb_drain_fsm u_drain_fsm (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .mem_resp  (mem_resp),
    .mem_write (mem_write),
    .pop       (pop),
    .beat_sel  (beat_sel)
  );

  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    if (mem_write) begin
      mem_address = {head_entry.tag, 5'b0};
      mem_wdata   = head_entry.line[32'(beat_sel) * s_beat +: s_beat];
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_line = '0;
    lkp_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      lkp_idx = head_q[IdxW-1:0] + IdxW'(k);
      if ((PtrW'(k) < count) && (entries_q[lkp_idx].tag == lkp_addr[31:5])) begin
        lkp_hit = 1'b1;
`ifdef L2_WB_FORWARD_EN
        lkp_line = entries_q[lkp_idx].line;
`else
        lkp_line = '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Scoreboard bench for l2_writeback_buffer: accepted pushes enqueue expected beats,
// accepted memory beats are popped and compared.
module tb_l2_writeback_buffer;

  logic         clk;
  logic         rst;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic [31:0]  lkp_addr;
  logic         lkp_hit;
  logic [255:0] lkp_line;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic         mem_resp;
  logic         empty;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    beats_seen = 0;
  int    resp_mode  = 0;
  int    gap        = 0;
  logic  resp_man   = 1'b0;
  logic  rnd_resp   = 1'b0;

  localparam logic [255:0] L0 = {64'h4444_4444_0000_0004, 64'h3333_3333_0000_0003,
                                 64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001};
  localparam logic [255:0] D1 = {4{64'hd1d1_0000_cafe_0001}};
  localparam logic [255:0] D2 = {4{64'hd2d2_0000_beef_0002}};

  l2_writeback_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_line     (wb_line),
    .lkp_addr    (lkp_addr),
    .lkp_hit     (lkp_hit),
    .lkp_line    (lkp_line),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_resp = (resp_mode != 0) ? rnd_resp : resp_man;

  always @(posedge clk) begin
    #1;
    if (gap != 0) begin
      rnd_resp = 1'b0;
      gap--;
    end else begin
      rnd_resp = 1'b1;
      gap = $urandom_range(0, 5);
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write && mem_resp) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check_eq("beat_with_no_expectation", 256'(exp_q.size()), 256'd1);
        end else begin
          mon_b = exp_q.pop_front();
          check_eq("mem_address", 256'(mem_address), 256'(mon_b.addr));
          check_eq("mem_wdata", 256'(mem_wdata), 256'(mon_b.data));
        end
      end
      if (wb_valid && wb_ready) begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back('{addr: {wb_addr[31:5], 5'b0}, data: wb_line[i*64 +: 64]});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] a, input logic [255:0] l);
    int n = 0;
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_line  = l;
    @(negedge clk);
    while (!wb_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wb_ready) check_eq("push_timeout", 256'(wb_ready), 256'd1);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!(empty && exp_q.size() == 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 256'(empty), 256'd1);
    check_eq({tag, "_sb"}, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wb_ready"}, 256'(wb_ready), 256'd1);
    check_eq({tag, "_empty"}, 256'(empty), 256'd1);
    check_eq({tag, "_mem_write"}, 256'(mem_write), 256'd0);
    check_eq({tag, "_mem_address"}, 256'(mem_address), 256'd0);
    check_eq({tag, "_mem_wdata"}, 256'(mem_wdata), 256'd0);
    check_eq({tag, "_lkp_hit"}, 256'(lkp_hit), 256'd0);
    check_eq({tag, "_lkp_line"}, lkp_line, 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  a;
    logic [255:0] l;
    int           k;
    logic [255:0] fwd_exp;

`ifdef L2_WB_FORWARD_EN
    fwd_exp = D2;
`else
    fwd_exp = '0;
`endif
    rst      = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_line  = '0;
    lkp_addr = '0;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single line drain: one idle cycle, then four beats.
    push(32'h0000_1000, L0);
    check_eq("t1_idle_after_push", 256'(mem_write), 256'd0);
    check_eq("t1_not_empty", 256'(empty), 256'd0);
    resp_man = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t1_burst_start", 256'(mem_write), 256'd1);
    check_eq("t1_burst_addr", 256'(mem_address), 256'h1000);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t1_write_drops", 256'(mem_write), 256'd0);
    check_eq("t1_empty", 256'(empty), 256'd1);
    check_eq("t1_sb", 256'(exp_q.size()), 256'd0);
    resp_man = 1'b0;

    // Fill to DEPTH, hold a third push until the first burst completes.
    push(32'h0000_1000, {4{64'haaaa_0000_0000_1000}});
    push(32'h0000_2000, {4{64'hbbbb_0000_0000_2000}});
    check_eq("t2_full_ready", 256'(wb_ready), 256'd0);
    check_eq("t2_head_addr", 256'(mem_address), 256'h1000);
    fork
      push(32'h0000_4000, {4{64'hcccc_0000_0000_4000}});
      begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("t2_full_holds", 256'(wb_ready), 256'd0);
        resp_man = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t2_idle_gap", 256'(mem_write), 256'd0);
        check_eq("t2_ready_after_pop", 256'(wb_ready), 256'd1);
      end
    join
    check_eq("t2_count_stays_2", 256'(wb_ready), 256'd0);
    check_eq("t2_next_head", 256'(mem_address), 256'h2000);
    wait_empty("t2_drain");
    resp_man = 1'b0;

    // Lookup: same-cycle push invisible, youngest match wins, head visible mid-burst.
    lkp_addr = 32'h0000_3000;
    wb_valid = 1'b1;
    wb_addr  = 32'h0000_3000;
    wb_line  = D1;
    #1;
    check_eq("t3_lkp_same_cycle", 256'(lkp_hit), 256'd0);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    check_eq("t3_lkp_after_push", 256'(lkp_hit), 256'd1);
    push(32'h0000_3004, D2);
    lkp_addr = 32'h0000_301C;
    #1;
    check_eq("t3_lkp_hit", 256'(lkp_hit), 256'd1);
    check_eq("t3_lkp_line_youngest", lkp_line, fwd_exp);
    lkp_addr = 32'h0000_7000;
    #1;
    check_eq("t3_lkp_miss", 256'(lkp_hit), 256'd0);
    check_eq("t3_lkp_miss_line", lkp_line, 256'd0);
    lkp_addr = 32'h0000_3010;
    resp_man = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t3_lkp_after_first_pop", 256'(lkp_hit), 256'd1);
    check_eq("t3_lkp_line_remaining", lkp_line, fwd_exp);
    wait_empty("t3_drain");
    check_eq("t3_lkp_cleared", 256'(lkp_hit), 256'd0);
    resp_man = 1'b0;

    // Reset after the first beat of a burst abandons it.
    lkp_addr = 32'h0000_5000;
    push(32'h0000_5000, L0);
    @(posedge clk);
    #1;
    check_eq("t5_burst", 256'(mem_write), 256'd1);
    resp_man = 1'b1;
    @(posedge clk);
    #1;
    resp_man = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("t5_midburst");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    resp_man = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_stray_resp_write", 256'(mem_write), 256'd0);
    check_eq("t5_stray_resp_empty", 256'(empty), 256'd1);
    resp_man = 1'b0;

    // Random response gaps over 100 pushes.
    beats_seen = 0;
    resp_mode  = 1;
    for (int n = 0; n < 100; n++) begin
      a = $urandom;
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push(a, l);
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty("t6_drain");
    check_eq("t6_beat_count", 256'(beats_seen), 256'd400);
    resp_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
